// File: rtl/mask_unit_read_response_xbar_pkg.sv
// -----------------------------------------------------------------------------
// mask_unit_xbar_pkg
// Shared constants, the buffered response entry type and the round-robin
// pick function used by the mask-unit lane read-response crossbar.
// -----------------------------------------------------------------------------
package mask_unit_xbar_pkg;

  localparam int LANES  = 4;   // lane response inputs (power of 2)
  localparam int REQS   = 4;   // requester outputs
  localparam int DATA_W = 32;  // read data width
  localparam int OFF_W  = 2;   // byte-group offset width
  localparam int IDX_W  = $clog2(REQS);
  localparam int LANE_W = $clog2(LANES);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  writeIndex;
    logic [OFF_W-1:0]  dataOffset;
  } resp_entry_t;

  // First set bit of req at or after ptr, wrapping modulo LANES.
  // Returns ptr when req is empty; callers qualify with |req.
  function automatic logic [LANE_W-1:0] rr_pick(input logic [LANES-1:0]  req,
                                               input logic [LANE_W-1:0] ptr);
    logic [LANE_W-1:0] idx;
    logic              found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      // LANES is a power of 2, so the index wraps for free.
      idx = ptr + LANE_W'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mask_unit_read_response_xbar_if.sv
// -----------------------------------------------------------------------------
// mask_unit_read_response_xbar_if
// Lane-side and requester-side signals of the read-response crossbar.
//   slave  : crossbar view (accepts lane responses, drives requesters)
//   master : environment view (lanes drive responses, requesters accept)
// Lane side     : in_valid, in_ready, in_data, in_writeIndex, in_dataOffset
// Requester side: out_valid, out_ready, out_data, out_dataOffset, out_lane
// -----------------------------------------------------------------------------
interface mask_unit_read_response_xbar_if;
  import mask_unit_xbar_pkg::*;

  logic [LANES-1:0]             in_valid;
  logic [LANES-1:0]             in_ready;
  logic [LANES-1:0][DATA_W-1:0] in_data;
  logic [LANES-1:0][IDX_W-1:0]  in_writeIndex;
  logic [LANES-1:0][OFF_W-1:0]  in_dataOffset;

  logic [REQS-1:0]              out_valid;
  logic [REQS-1:0]              out_ready;
  logic [REQS-1:0][DATA_W-1:0]  out_data;
  logic [REQS-1:0][OFF_W-1:0]   out_dataOffset;
  logic [REQS-1:0][LANE_W-1:0]  out_lane;

  modport slave (
    input  in_valid, in_data, in_writeIndex, in_dataOffset, out_ready,
    output in_ready, out_valid, out_data, out_dataOffset, out_lane
  );

  modport master (
    output in_valid, in_data, in_writeIndex, in_dataOffset, out_ready,
    input  in_ready, out_valid, out_data, out_dataOffset, out_lane
  );

endinterface

// File: rtl/mask_unit_resp_fifo.sv
// -----------------------------------------------------------------------------
// mask_unit_resp_fifo
// DEPTH-entry response FIFO for one lane. No bypass: a push becomes visible
// at rdata_o in the following cycle.
//   clock, reset : clock, synchronous active-high reset
//   push_i       : write wdata_i (caller guarantees !full_o)
//   pop_i        : drop the head entry (caller guarantees !empty_o)
//   rdata_o      : head entry
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
// -----------------------------------------------------------------------------
module mask_unit_resp_fifo
  import mask_unit_xbar_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push_i,
  input  logic        pop_i,
  input  resp_entry_t wdata_i,
  output resp_entry_t rdata_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; that is what keeps synthesis from inferring a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    // Simultaneous push and pop leaves the count unchanged.
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; emptiness is tracked by
  // count_q, so stale contents are never observed and the RAM stays reset-free.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/mask_unit_read_response_xbar.sv
// -----------------------------------------------------------------------------
// mask_unit_read_response_xbar
// Return path of the mask-unit lane read crossbar. Each lane's response is
// buffered in a small FIFO (lanes cannot be stalled once a read is issued) and
// steered to the requester named by its writeIndex. Each requester runs its
// own round-robin arbiter over the lane FIFO heads that target it.
//   clock, reset : clock, synchronous active-high reset
//   bus          : lane responses in, requester responses out (slave view)
//   overflow     : sticky; a response arrived while its lane FIFO was full
// -----------------------------------------------------------------------------
module mask_unit_read_response_xbar
  import mask_unit_xbar_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  mask_unit_read_response_xbar_if.slave  bus,
  output logic                           overflow
);

  resp_entry_t       head      [LANES];
  logic [LANES-1:0]  full, empty, push, pop;
  logic [LANES-1:0]  cand      [REQS];
  logic [LANE_W-1:0] winner    [REQS];
  logic [LANE_W-1:0] rr_ptr_q  [REQS];
  logic [LANE_W-1:0] rr_ptr_d  [REQS];
  logic [REQS-1:0]   fire;
  logic [REQS-1:0]   out_valid;
  logic              overflow_q, overflow_d;

  // in_ready depends only on registered FIFO state: a full FIFO that pops this
  // cycle still refuses the incoming beat.
  assign bus.in_ready = ~full;
  assign push         = bus.in_valid & ~full;
  assign overflow_d   = overflow_q | (|(bus.in_valid & full));
  assign overflow     = overflow_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    resp_entry_t wdata;
    assign wdata = '{data:       bus.in_data[l],
                     writeIndex: bus.in_writeIndex[l],
                     dataOffset: bus.in_dataOffset[l]};

    mask_unit_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (push[l]),
      .pop_i   (pop[l]),
      .wdata_i (wdata),
      .rdata_o (head[l]),
      .full_o  (full[l]),
      .empty_o (empty[l])
    );

    // writeIndex values outside the requester range would wedge this FIFO.
    a_legal_index : assert property (@(posedge clock) disable iff (reset)
      !bus.in_valid[l] || (int'(bus.in_writeIndex[l]) < REQS));
  end

  always_comb begin
    pop       = '0;
    out_valid = '0;
    for (int r = 0; r < REQS; r++) begin
      cand[r] = '0;
      for (int l = 0; l < LANES; l++) begin
        cand[r][l] = !empty[l] && (head[l].writeIndex == IDX_W'(r));
      end
      winner[r]    = rr_pick(cand[r], rr_ptr_q[r]);
      out_valid[r] = |cand[r];
      fire[r]      = out_valid[r] & bus.out_ready[r];
      rr_ptr_d[r]  = fire[r] ? winner[r] + 1'b1 : rr_ptr_q[r];
      // A head targets exactly one requester, so each lane pops at most once.
      if (fire[r]) pop[winner[r]] = 1'b1;
    end
  end

  assign bus.out_valid = out_valid;
  for (genvar r = 0; r < REQS; r++) begin : g_req
    assign bus.out_data[r]       = head[winner[r]].data;
    assign bus.out_dataOffset[r] = head[winner[r]].dataOffset;
    assign bus.out_lane[r]       = winner[r];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < REQS; r++) rr_ptr_q[r] <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int r = 0; r < REQS; r++) rr_ptr_q[r] <= rr_ptr_d[r];
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_mask_unit_read_response_xbar.sv
// -----------------------------------------------------------------------------
// tb_mask_unit_read_response_xbar
// Directed scenarios followed by randomized traffic, compared every cycle
// against a queue-based reference model of the crossbar.
// -----------------------------------------------------------------------------
module tb_mask_unit_read_response_xbar;

  localparam int NL    = 4;
  localparam int NR    = 4;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  wi;
    logic [1:0]  off;
  } ent_t;

  logic clk;
  logic reset;
  logic overflow;

  mask_unit_read_response_xbar_if bus ();

  mask_unit_read_response_xbar #(.DEPTH(DEPTH)) dut (
    .clock    (clk),
    .reset    (reset),
    .bus      (bus),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-lane ordered buffers, per-requester next-search lane.
  ent_t mq   [NL][DEPTH];
  int   mcnt [NL];
  int   mrr  [NR];
  bit   movf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int l = 0; l < NL; l++) mcnt[l] = 0;
    for (int r = 0; r < NR; r++) mrr[r] = 0;
    movf = 1'b0;
  endtask

  // One clock cycle: compare outputs at the falling edge, then advance the
  // model across the rising edge using the inputs currently driven.
  task automatic step(input bit do_reset = 1'b0);
    int  win    [NR];
    bit  fire_m [NR];
    int  pre    [NL];
    bit  exp_v;
    ent_t e;
    reset = do_reset;
    @(negedge clk);
    for (int r = 0; r < NR; r++) begin
      exp_v  = 1'b0;
      win[r] = 0;
      for (int i = 0; i < NL; i++) begin
        int l;
        l = (mrr[r] + i) % NL;
        if (!exp_v && mcnt[l] > 0 && int'(mq[l][0].wi) == r) begin
          exp_v  = 1'b1;
          win[r] = l;
        end
      end
      check($sformatf("out_valid[%0d]", r), bus.out_valid[r], exp_v);
      if (exp_v) begin
        check($sformatf("out_data[%0d]", r), bus.out_data[r], mq[win[r]][0].data);
        check($sformatf("out_off[%0d]", r), bus.out_dataOffset[r], mq[win[r]][0].off);
        check($sformatf("out_lane[%0d]", r), bus.out_lane[r], win[r]);
      end
      fire_m[r] = exp_v && bus.out_ready[r];
    end
    for (int l = 0; l < NL; l++)
      check($sformatf("in_ready[%0d]", l), bus.in_ready[l], mcnt[l] < DEPTH);
    check("overflow", overflow, movf);
    @(posedge clk);
    if (do_reset) begin
      model_clear();
    end else begin
      for (int l = 0; l < NL; l++) pre[l] = mcnt[l];
      for (int r = 0; r < NR; r++) begin
        if (fire_m[r]) begin
          for (int k = 0; k < DEPTH - 1; k++) mq[win[r]][k] = mq[win[r]][k+1];
          mcnt[win[r]]--;
          mrr[r] = (win[r] + 1) % NL;
        end
      end
      for (int l = 0; l < NL; l++) begin
        if (bus.in_valid[l]) begin
          if (pre[l] < DEPTH) begin
            e.data = bus.in_data[l];
            e.wi   = bus.in_writeIndex[l];
            e.off  = bus.in_dataOffset[l];
            mq[l][mcnt[l]] = e;
            mcnt[l]++;
          end else begin
            movf = 1'b1;
          end
        end
      end
    end
    #1;
    reset = 1'b0;
  endtask

  task automatic idle();
    bus.in_valid = '0;
  endtask

  task automatic set_lane(input int l, input logic [31:0] d, input int wi, input int off);
    bus.in_valid[l]      = 1'b1;
    bus.in_data[l]       = d;
    bus.in_writeIndex[l] = 2'(wi);
    bus.in_dataOffset[l] = 2'(off);
  endtask

  initial begin
    int lanes_exp [3];
    lanes_exp = '{0, 1, 3};

    bus.in_valid      = '0;
    bus.in_data       = '0;
    bus.in_writeIndex = '0;
    bus.in_dataOffset = '0;
    bus.out_ready     = '1;
    reset             = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    check("rst_out_valid", bus.out_valid, 4'h0);
    check("rst_in_ready", bus.in_ready, 4'hF);
    check("rst_overflow", overflow, 1'b0);
    step();

    // Single response: lane 2 -> requester 1, visible the next cycle.
    set_lane(2, 32'hDEADBEEF, 1, 3);
    step();
    idle();
    check("single_valid", bus.out_valid, 4'b0010);
    check("single_data", bus.out_data[1], 32'hDEADBEEF);
    check("single_off", bus.out_dataOffset[1], 2'd3);
    check("single_lane", bus.out_lane[1], 2'd2);
    step();
    check("single_empty", bus.out_valid, 4'h0);

    // Contention: lanes 0, 1, 3 -> requester 0, delivered in lane order.
    set_lane(0, 32'h1000_0000, 0, 0);
    set_lane(1, 32'h1111_1111, 0, 1);
    set_lane(3, 32'h1333_3333, 0, 2);
    step();
    idle();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("contend_lane%0d", k), bus.out_lane[0], lanes_exp[k]);
      step();
    end
    check("contend_empty", bus.out_valid[0], 1'b0);
    // Pointer wrapped back to 0: lane 0 wins over lane 1 next.
    set_lane(1, 32'h2111_1111, 0, 0);
    set_lane(0, 32'h2000_0000, 0, 0);
    step();
    idle();
    check("rr_wrap_lane", bus.out_lane[0], 2'd0);
    step();
    step();

    // Parallel routing: four lanes to four distinct requesters.
    for (int l = 0; l < NL; l++) set_lane(l, $urandom, 3 - l, l);
    step();
    idle();
    check("parallel_valid", bus.out_valid, 4'hF);
    step();
    check("parallel_empty", bus.out_valid, 4'h0);
    check("parallel_ready", bus.in_ready, 4'hF);

    // Backpressure and overflow on lane 0 -> requester 2.
    bus.out_ready = 4'b1011;
    set_lane(0, 32'hA000_0000, 2, 0);
    step();
    check("bp_ready1", bus.in_ready[0], 1'b1);
    set_lane(0, 32'hA000_0001, 2, 1);
    step();
    check("bp_ready2", bus.in_ready[0], 1'b0);
    check("bp_ovf_before", overflow, 1'b0);
    set_lane(0, 32'hA000_0002, 2, 2);
    step();
    idle();
    check("bp_ovf_after", overflow, 1'b1);
    check("bp_head0", bus.out_data[2], 32'hA000_0000);
    bus.out_ready = '1;
    step();
    check("bp_head1", bus.out_data[2], 32'hA000_0001);
    step();
    check("bp_drained", bus.out_valid[2], 1'b0);

    // Same-cycle push and pop on lane 1.
    set_lane(1, 32'hE000_0000, 0, 0);
    step();
    set_lane(1, 32'hE000_0001, 0, 1);
    step();
    idle();
    check("pp_valid", bus.out_valid[0], 1'b1);
    check("pp_data", bus.out_data[0], 32'hE000_0001);
    check("pp_ready", bus.in_ready[1], 1'b1);
    step();

    // Reset mid-operation with buffered data and overflow set.
    bus.out_ready = '0;
    for (int l = 0; l < NL; l++) set_lane(l, $urandom, l, 0);
    step();
    step();
    idle();
    step(1'b1);
    bus.out_ready = '1;
    check("midrst_valid", bus.out_valid, 4'h0);
    check("midrst_ready", bus.in_ready, 4'hF);
    check("midrst_ovf", overflow, 1'b0);
    step();

    // Randomized traffic, with one reset partway through.
    for (int c = 0; c < 600; c++) begin
      for (int l = 0; l < NL; l++) begin
        if ($urandom_range(0, 1) == 1)
          set_lane(l, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        else
          bus.in_valid[l] = 1'b0;
      end
      bus.out_ready = 4'($urandom);
      step(c == 300);
    end
    idle();
    bus.out_ready = '1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mask_unit_read_response_xbar.md
Name: mask_unit_read_response_xbar

Overview:
- Return path of the mask-unit lane read crossbar: per-lane read responses, tagged with the writeIndex that the request crossbar attached, are steered back to the originating requester.
- Lanes cannot be stalled once a read is issued, so each lane has a small response FIFO.
- Each requester port has its own round-robin arbiter across lanes.
- Sits between the lane VRF read-data outputs and the mask-unit requester slots.

Parameters:
- LANES, 4, number of lane response inputs (power of 2)
- REQS, 4, number of requester outputs; writeIndex width = log2(REQS)
- DATA_W, 32, read data width
- DEPTH, 2, per-lane response FIFO entries (≥1)

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  LANES  lane l returns read data this cycle
- in_ready  out  LANES  lane l FIFO not full; lane may issue a new read only when high
- in_data  in  LANES*DATA_W  read data per lane
- in_writeIndex  in  LANES*2  destination requester per lane
- in_dataOffset  in  LANES*2  byte-group offset, passed through unchanged
- out_valid  out  REQS  response available for requester r
- out_ready  in  REQS  requester r accepts
- out_data  out  REQS*DATA_W  routed data
- out_dataOffset  out  REQS*2  passed-through offset
- out_lane  out  REQS*2  source lane index of the delivered response
- overflow  out  1  sticky error: a response arrived while its FIFO was full

Behaviour:
- Reset values: all FIFOs empty, all round-robin pointers 0, overflow 0, out_valid 0, in_ready all 1.
- FIFO push:
  - lane l pushes {data, writeIndex, dataOffset} when in_valid[l] is high and count_l < DEPTH.
  - in_ready[l] = (count_l < DEPTH). It is registered-state only, with no combinational path from out_ready.
- FIFO overflow: if in_valid[l] is high while count_l == DEPTH, the beat is dropped, the FIFO is unchanged, and overflow is set to 1. overflow clears only on reset.
- Latency: a push in cycle t is visible at the FIFO head, and eligible for out_valid, in cycle t+1. There is no bypass.
- Candidates: cand[r][l] = FIFO_l non-empty and head_l.writeIndex == r.
- Arbitration per requester r:
  - Round-robin over cand[r], starting search at rr_ptr[r].
  - out_valid[r] = |cand[r]. Data, offset and lane are muxed from the winner's head.
- Pop: lane l pops when it is the winner for r = head_l.writeIndex and out_ready[r] is high. A lane head targets exactly one requester, so at most one pop per lane per cycle.
- Pointer update: on fire (out_valid[r] & out_ready[r]), rr_ptr[r] ← (winner+1) mod LANES. Otherwise the pointer holds.
- Simultaneous push and pop on the same lane in the same cycle: count is unchanged and ordering is preserved. in_ready reflects the pre-pop count, so a full FIFO with a pop this cycle still reports in_ready = 0.
- Ordering:
  - Per-lane FIFO order is strict.
  - Responses from different lanes to one requester may reorder. The requester reassembles using dataOffset/out_lane.
- Output stability: out_valid plus payload hold while out_ready is low, provided no higher-priority candidate appears. Winner changes are allowed only when rr_ptr changes or a new candidate arrives. Requesters must not depend on stability.
- Reset mid-operation: all buffered responses are discarded; out_valid drops in the cycle after reset is sampled high.
- Widths: writeIndex values ≥ REQS (only when REQS is not a power of 2) never match any output; that entry would block its FIFO. Upstream guarantees legal values; an assertion flags violations.

Decomposition:
- Shared package (mask_unit_xbar_pkg):
  - LANES, REQS, DATA_W constants
  - IDX_W = $clog2(REQS)
  - typedef resp_entry_t {data, writeIndex, dataOffset}
- Sub-module: mask_unit_resp_fifo (DEPTH-entry FIFO with count, full, empty), instantiated once per lane.
- Round-robin arbitration is a function in the package, not a separate module.

Test Plan:
- Single response: lane 2 returns data 0xDEADBEEF, writeIndex 1, offset 3 at cycle 5 → out_valid[1] = 1 at cycle 6 with data 0xDEADBEEF, offset 3, out_lane 2; FIFO 2 empty after the fire.
- Contention and fairness: lanes 0, 1 and 3 each push one response to requester 0 at cycle 0, with out_ready[0] = 1 → delivered cycles 1, 2, 3 in lane order 0, 1, 3; rr_ptr[0] ends at 0.
- Parallel routing: four lanes target four distinct requesters in one cycle, all out_ready = 1 → all four out_valid high in the same cycle; every FIFO empties.
- Backpressure and full: out_ready[2] = 0 and lane 0 pushes three responses to requester 2 (DEPTH = 2) → in_ready[0] = 0 after 2 pushes; the third is dropped and overflow = 1; releasing out_ready delivers only the first two, in order.
- Same-cycle push and pop: lane 1 FIFO holds 1 entry, pop and push occur together → count stays 1; the next delivered data equals the newly pushed value.
- Reset mid-operation: assert reset for 1 cycle with FIFOs holding data and overflow = 1 → next cycle all out_valid = 0, in_ready all 1, overflow = 0.
